// File: rtl/uart_rx_pkg.sv
// Shared definitions for the parametrised UART receiver.
//   state_t           : receiver FSM states
//   PAR_*             : parity mode encodings for the PARITY parameter
//   calc_baud_div     : clocks per bit, truncated, never below 4
//   calc_half         : clocks to the middle of the start bit
//   clamp_range       : forces a parameter into its legal range
package uart_rx_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BRK_WAIT
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    function automatic int calc_baud_div(input int clk_hz, input int baud);
        int d;
        if (baud <= 0) begin
            return 4;
        end
        d = clk_hz / baud;
        if (d < 4) begin
            d = 4;
        end
        return d;
    endfunction

    function automatic int calc_half(input int baud_div);
        return baud_div / 2;
    endfunction

    function automatic int clamp_range(input int v, input int lo, input int hi);
        if (v < lo) begin
            return lo;
        end
        if (v > hi) begin
            return hi;
        end
        return v;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line.
//   iclk   : clock
//   irst_n : synchronous active-low reset, both stages reset to 1 (idle line)
//   din    : asynchronous input
//   dout   : synchronised output
module uart_rx_sync (
    input  logic iclk,
    input  logic irst_n,
    input  logic din,
    output logic dout
);

    logic meta;

    always_ff @(posedge iclk) begin
        if (!irst_n) begin
            meta <= 1'b1;
            dout <= 1'b1;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with valid/ready holding register.
//   iclk, irst_n  : clock, synchronous active-low reset
//   uart_rx_i     : asynchronous serial line, idle high
//   rx_data_o     : received word, LSB-aligned, unused upper bits 0
//   rx_valid_o    : holding register full; rx_ready_i accepts it
//   parity_err_o  : parity mismatch on held word
//   frame_err_o   : a stop bit sampled 0 on held word
//   break_o       : one-cycle pulse when a break is detected
//   overrun_o     : one-cycle pulse when a completed word is dropped
//   busy_o        : receiver not idle
module uart_rx_param import uart_rx_pkg::*; #(
    parameter int CLK_HZ    = 100_000_000,
    parameter int BAUD      = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       iclk,
    input  logic       irst_n,
    input  logic       uart_rx_i,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    output logic       parity_err_o,
    output logic       frame_err_o,
    output logic       break_o,
    output logic       overrun_o,
    output logic       busy_o
);

    localparam int BAUD_DIV = calc_baud_div(CLK_HZ, BAUD);
    localparam int HALF     = calc_half(BAUD_DIV);
    localparam int DBITS    = clamp_range(DATA_BITS, 5, 8);
    localparam int NSTOP    = clamp_range(STOP_BITS, 1, 2);
    localparam int CW       = $clog2(BAUD_DIV);

    state_t        state;
    logic          rxs;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic [7:0]    data_word;
    logic          perr;
    logic          ferr;
    logic          all_zero;
    logic          armed;
    logic [1:0]    fill;
    logic          sample_tick;
    logic          stop_last;
    logic          is_brk;
    logic          hs;

    uart_rx_sync u_sync (
        .iclk   (iclk),
        .irst_n (irst_n),
        .din    (uart_rx_i),
        .dout   (rxs)
    );

    // Bits arrive LSB-first into the top of the shifter, so a short word
    // ends up left-aligned and is shifted down here.
    assign data_word = shift >> (8 - DBITS);
    assign hs        = rx_valid_o & rx_ready_i;
    assign busy_o    = (state != S_IDLE);

    always_comb begin
        sample_tick = 1'b0;
        case (state)
            S_START:                  sample_tick = (cnt == CW'(HALF - 1));
            S_DATA, S_PARITY, S_STOP: sample_tick = (cnt == CW'(BAUD_DIV - 1));
            default:                  sample_tick = 1'b0;
        endcase
    end

    assign stop_last = sample_tick && (state == S_STOP) && (bit_idx == 3'(NSTOP - 1));
    assign is_brk    = all_zero & ~rxs;

    always_ff @(posedge iclk) begin
        if (!irst_n) begin
            state        <= S_IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            shift        <= '0;
            perr         <= 1'b0;
            ferr         <= 1'b0;
            all_zero     <= 1'b0;
            armed        <= 1'b0;
            fill         <= '0;
            rx_data_o    <= '0;
            rx_valid_o   <= 1'b0;
            parity_err_o <= 1'b0;
            frame_err_o  <= 1'b0;
            break_o      <= 1'b0;
            overrun_o    <= 1'b0;
        end else begin
            break_o   <= 1'b0;
            overrun_o <= 1'b0;
            if (hs) begin
                rx_valid_o <= 1'b0;
            end

            // The synchroniser holds its reset value of 1 for two cycles
            // after reset; only a genuinely sampled high line may arm the
            // receiver, otherwise a line held low across reset would be
            // mistaken for a start bit.
            if (fill != 2'd2) begin
                fill <= fill + 2'd1;
            end
            if (fill == 2'd2 && rxs) begin
                armed <= 1'b1;
            end

            if (state == S_IDLE || state == S_BRK_WAIT || sample_tick) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end

            case (state)
                S_IDLE: begin
                    if (armed && !rxs) begin
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (sample_tick) begin
                        if (rxs) begin
                            state <= S_IDLE;
                        end else begin
                            state    <= S_DATA;
                            bit_idx  <= '0;
                            all_zero <= 1'b1;
                            perr     <= 1'b0;
                            ferr     <= 1'b0;
                        end
                    end
                end
                S_DATA: begin
                    if (sample_tick) begin
                        shift    <= {rxs, shift[7:1]};
                        all_zero <= all_zero & ~rxs;
                        if (bit_idx == 3'(DBITS - 1)) begin
                            bit_idx <= '0;
                            state   <= (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                S_PARITY: begin
                    if (sample_tick) begin
                        perr     <= ((^data_word) ^ rxs) != (PARITY == PAR_ODD);
                        all_zero <= all_zero & ~rxs;
                        bit_idx  <= '0;
                        state    <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (sample_tick) begin
                        ferr     <= ferr | ~rxs;
                        all_zero <= all_zero & ~rxs;
                        if (stop_last) begin
                            if (!rx_valid_o || hs) begin
                                rx_data_o    <= data_word;
                                parity_err_o <= perr;
                                frame_err_o  <= ferr | ~rxs;
                                rx_valid_o   <= 1'b1;
                            end else begin
                                overrun_o <= 1'b1;
                            end
                            break_o <= is_brk;
                            state   <= is_brk ? S_BRK_WAIT : S_IDLE;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                S_BRK_WAIT: begin
                    if (rxs) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
